led_scan_ctrl: RTL and testbench
================================

Name: led_scan_ctrl

Overview:
- Upstream stage for the 3-to-8 enabled decoder. Generates the 3-bit index `idx` and its enable `idx_en` that drive the decoder.
- Together with the decoder, forms a running-light (LED chaser) on the board's 8 LEDs.
- Supports a free-running prescaled scan, pause, single-step, direction control and ping-pong (bounce) mode.

Parameters:
- DIV_W, 24, prescaler counter width.
- DIV_MAX, 24'd4999999, prescaler terminal count. The index advances every DIV_MAX+1 clocks; must be >= 1.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset; deassertion synchronous to clk externally.
- clr  in  1  synchronous clear; returns block to IDLE.
- run  in  1  level; 1 = scan automatically, 0 = hold.
- step  in  1  single-step request; rising edge detected internally.
- dir  in  1  0 = increment, 1 = decrement (non-bounce mode; initial direction in bounce mode).
- bounce  in  1  1 = ping-pong between 0 and 7.
- idx  out  3  index to decoder x.
- idx_en  out  1  enable to decoder E.
- tick  out  1  one-cycle pulse on every index change.
- wrap  out  1  one-cycle pulse when idx leaves an end position (7->0 or 0->7 wrap; or direction reversal in bounce).

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; idx=0, idx_en=0, tick=0, wrap=0.
  - prescaler=0, step edge register=0, bounce direction flag=0.
- States:
  - IDLE: idx=0, idx_en=0, prescaler held at 0. run=1 -> RUN next cycle with idx_en=1, idx=0 (dir=1 and not bounce: idx=7).
  - RUN: prescaler increments each clock. At prescaler==DIV_MAX: prescaler->0, idx advances, tick=1 for that cycle. run=0 -> PAUSE, with prescaler and idx frozen.
  - PAUSE: idx_en stays 1, idx held. A step rising edge advances idx once, with tick=1. run=1 -> RUN, prescaler restarts from 0.
- Step edge detect: step_q registers step; a step edge is step & ~step_q. Edges in IDLE and RUN are ignored.
- Advance rule, non-bounce: idx +/- 1 mod 8 per dir, sampled at the advance cycle. wrap=1 on 7->0 (up) or 0->7 (down).
- Advance rule, bounce: the internal flag selects the direction.
  - At idx==7 going up: flag flips and idx->6, wrap=1.
  - At idx==0 going down: flag flips and idx->1, wrap=1.
  - The flag is loaded from dir on entry to RUN from IDLE, and whenever bounce goes 0->1.
- Output timing: tick and wrap are registered and coincide with the cycle in which the new idx is visible; both are 0 otherwise.
- Priority:
  - Highest to lowest: rst > clr > run transitions > advance.
  - clr in any state: next cycle IDLE, idx=0, idx_en=0, no tick.
  - run falling in the same cycle as the terminal count: advance still happens, then PAUSE.
- Width rules:
  - Prescaler compares equal to DIV_MAX, never greater.
  - idx arithmetic is 3-bit modulo.
- Latency: from run rising in IDLE, idx_en=1 one cycle later. The first advance occurs DIV_MAX+1 cycles after entering RUN.

Decomposition:
- Shared package `scan_pkg`:
  - state enum {IDLE, RUN, PAUSE} as 2-bit localparams.
  - IDX_W=3, IDX_MAX=3'd7.
- One sub-module `scan_prescaler` holds the DIV_W counter. Inputs: enable, clear. Output: a terminal-count pulse.
- The FSM, edge detect and index logic stay in the top.

Test Plan (DIV_MAX=3):
- Reset/IDLE: rst=0 then 1, run=0 for 20 cycles -> idx=0, idx_en=0, tick=0 throughout.
- Up scan wrap: run=1, dir=0, bounce=0 -> idx_en=1 next cycle; idx 0,1,...,7,0 changes every 4 cycles; wrap=1 only on the 7->0 cycle.
- Down and bounce:
  - dir=1, bounce=0 from IDLE: idx 7,6,...,0,7.
  - bounce=1, dir=0: idx 0..7,6..0,1; wrap pulses at the 7->6 and 0->1 cycles.
- Pause/step:
  - Run to idx=3, run=0: idx holds 3 for 50 cycles, idx_en=1.
  - Three step pulses (each high 5 cycles): idx 4,5,6, exactly three ticks.
  - step held high continuously: exactly one advance.
- Priority/clear:
  - clr=1 in PAUSE at idx=5 -> next cycle idx=0, idx_en=0, state IDLE.
  - clr and run both high -> remains IDLE.
- Async reset mid-RUN: assert rst between clock edges at idx=6 -> outputs go to 0 immediately without a clock edge; after release with run=1, the scan restarts at idx=0.

Source files
------------

// File: rtl/led_scan_ctrl_pkg.sv
// Shared types and helpers for the LED scan controller: FSM states and the
// index-advance rule used by both plain wrap-around and ping-pong scanning.
package scan_pkg;

  localparam int IDX_W = 3;
  localparam logic [IDX_W-1:0] IDX_MAX = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } scan_state_t;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             wrap;
    logic             flip;
  } scan_adv_t;

  // One step from cur; at an end position bounce mode reflects instead of wrapping.
  function automatic scan_adv_t next_idx(input logic [IDX_W-1:0] cur,
                                         input logic down,
                                         input logic bnc);
    scan_adv_t a;
    a.idx  = cur;
    a.wrap = 1'b0;
    a.flip = 1'b0;
    if (down) begin
      if (cur == 3'd0) begin
        a.wrap = 1'b1;
        a.flip = bnc;
        a.idx  = bnc ? 3'd1 : IDX_MAX;
      end else begin
        a.idx = cur - 3'd1;
      end
    end else begin
      if (cur == IDX_MAX) begin
        a.wrap = 1'b1;
        a.flip = bnc;
        a.idx  = bnc ? (IDX_MAX - 3'd1) : 3'd0;
      end else begin
        a.idx = cur + 3'd1;
      end
    end
    return a;
  endfunction

endpackage

// File: rtl/led_scan_ctrl_if.sv
// Control/status bundle between a board-level controller and led_scan_ctrl.
interface led_scan_if;
  import scan_pkg::*;

  logic             clr;
  logic             run;
  logic             step;
  logic             dir;
  logic             bounce;
  logic [IDX_W-1:0] idx;
  logic             idx_en;
  logic             tick;
  logic             wrap;

  modport master (output clr, run, step, dir, bounce,
                  input  idx, idx_en, tick, wrap);
  modport slave  (input  clr, run, step, dir, bounce,
                  output idx, idx_en, tick, wrap);
endinterface

// File: rtl/scan_prescaler.sv
// Prescaler for the LED scan: counts 0..DIV_MAX while enabled and flags the
// terminal count so the index advances once every DIV_MAX+1 clocks.
module scan_prescaler #(
  parameter int              DIV_W   = 24,
  parameter logic [DIV_W-1:0] DIV_MAX = 24'd4999999
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tc
);

  logic [DIV_W-1:0] cnt_r;

  // Terminal count is an exact match; the counter never runs past DIV_MAX.
  assign tc = en && (cnt_r == DIV_MAX);

  // Counter: clear wins over enable, holds when idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= {DIV_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {DIV_W{1'b0}};
    end else if (en) begin
      cnt_r <= (cnt_r == DIV_MAX) ? {DIV_W{1'b0}} : cnt_r + {{(DIV_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/led_scan_ctrl.sv
// LED chaser index generator feeding a 3-to-8 decoder: prescaled scan with
// pause, single-step, direction and ping-pong control.
module led_scan_ctrl
  import scan_pkg::*;
#(
  parameter int              DIV_W   = 24,
  parameter logic [DIV_W-1:0] DIV_MAX = 24'd4999999
) (
  input logic      clk,
  input logic      rst,
  led_scan_if.slave bus
);

  scan_state_t      state_r;
  logic [IDX_W-1:0] idx_r;
  logic             idx_en_r;
  logic             tick_r;
  logic             wrap_r;
  logic             step_q_r;
  logic             bounce_q_r;
  logic             bdir_r;

  logic      tc_s;
  logic      pre_en_s;
  logic      pre_clr_s;
  logic      step_edge_s;
  logic      brise_s;
  logic      down_s;
  logic      adv_s;
  scan_adv_t adv_a_s;

  assign step_edge_s = bus.step & ~step_q_r;
  assign brise_s     = bus.bounce & ~bounce_q_r;
  // A bounce request arriving this cycle seeds the direction straight from dir.
  assign down_s      = bus.bounce ? (brise_s ? bus.dir : bdir_r) : bus.dir;
  assign adv_a_s     = next_idx(idx_r, down_s, bus.bounce);

  assign pre_en_s  = (state_r == RUN);
  assign pre_clr_s = bus.clr || (state_r == IDLE) || ((state_r == PAUSE) && bus.run);

  // Step is only honoured while paused and not being resumed in the same cycle.
  assign adv_s = !bus.clr &&
                 (((state_r == RUN) && tc_s) ||
                  ((state_r == PAUSE) && !bus.run && step_edge_s));

  scan_prescaler #(.DIV_W(DIV_W), .DIV_MAX(DIV_MAX)) u_prescaler (
    .clk (clk),
    .rst (rst),
    .en  (pre_en_s),
    .clr (pre_clr_s),
    .tc  (tc_s)
  );

  // Scan FSM with registered index, enable and event pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      idx_r      <= 3'd0;
      idx_en_r   <= 1'b0;
      tick_r     <= 1'b0;
      wrap_r     <= 1'b0;
      step_q_r   <= 1'b0;
      bounce_q_r <= 1'b0;
      bdir_r     <= 1'b0;
    end else begin
      step_q_r   <= bus.step;
      bounce_q_r <= bus.bounce;
      tick_r     <= 1'b0;
      wrap_r     <= 1'b0;
      if (brise_s) begin
        bdir_r <= bus.dir;
      end else begin
        bdir_r <= bdir_r;
      end
      if (bus.clr) begin
        state_r  <= IDLE;
        idx_r    <= 3'd0;
        idx_en_r <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            if (bus.run) begin
              state_r  <= RUN;
              idx_en_r <= 1'b1;
              idx_r    <= (bus.dir && !bus.bounce) ? IDX_MAX : 3'd0;
              bdir_r   <= bus.dir;
            end else begin
              idx_r    <= 3'd0;
              idx_en_r <= 1'b0;
            end
          end
          RUN:     state_r <= bus.run ? RUN : PAUSE;
          PAUSE:   state_r <= bus.run ? RUN : PAUSE;
          default: begin
            state_r  <= IDLE;
            idx_r    <= 3'd0;
            idx_en_r <= 1'b0;
          end
        endcase
        if (adv_s) begin
          idx_r  <= adv_a_s.idx;
          tick_r <= 1'b1;
          wrap_r <= adv_a_s.wrap;
          if (adv_a_s.flip) begin
            bdir_r <= ~down_s;
          end else begin
            bdir_r <= down_s;
          end
        end
      end
    end
  end

  assign bus.idx    = idx_r;
  assign bus.idx_en = idx_en_r;
  assign bus.tick   = tick_r;
  assign bus.wrap   = wrap_r;

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Self-checking bench for led_scan_ctrl: behavioural model compared every cycle
// plus literal index sequences for scan, bounce, pause/step, clear and reset.
module tb_led_scan_ctrl;

  localparam int DIV_MAX = 3;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;

  logic clk;
  logic rst;
  led_scan_if bus();

  led_scan_ctrl #(.DIV_W(24), .DIV_MAX(24'd3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  bit chk_en   = 1'b0;
  int tick_q[$];
  int wrap_q[$];

  typedef struct {
    int mode;
    int cnt;
    int idx;
    int en;
    int tick;
    int wrap;
    int bdir;
    bit step_q;
    bit bounce_q;
  } mdl_t;

  mdl_t mdl;

  function automatic mdl_t mdl_reset();
    mdl_t n;
    n.mode = M_IDLE; n.cnt = 0; n.idx = 0; n.en = 0; n.tick = 0; n.wrap = 0;
    n.bdir = 1; n.step_q = 1'b0; n.bounce_q = 1'b0;
    return n;
  endfunction

  // Spec-level model: position moves by +/-1, leaving 0..7 either wraps or reflects.
  function automatic mdl_t mdl_next(mdl_t m, logic c, logic r, logic s, logic d, logic b);
    mdl_t n;
    int   t;
    int   dv;
    bit   adv;
    n = m; n.tick = 0; n.wrap = 0; n.step_q = s; n.bounce_q = b; adv = 1'b0;
    if (b && !m.bounce_q) n.bdir = d ? -1 : 1;
    if (c) begin
      n.mode = M_IDLE; n.idx = 0; n.en = 0; n.cnt = 0;
    end else if (m.mode == M_IDLE) begin
      if (r) begin
        n.mode = M_RUN; n.en = 1; n.cnt = 0; n.idx = (d && !b) ? 7 : 0; n.bdir = d ? -1 : 1;
      end
    end else if (m.mode == M_RUN) begin
      adv   = (m.cnt == DIV_MAX);
      n.cnt = adv ? 0 : m.cnt + 1;
      if (!r) n.mode = M_PAUSE;
    end else begin
      if (r) begin
        n.mode = M_RUN; n.cnt = 0;
      end else begin
        adv = s && !m.step_q;
      end
    end
    if (adv) begin
      dv = b ? n.bdir : (d ? -1 : 1);
      t  = m.idx + dv;
      if (t < 0 || t > 7) begin
        n.wrap = 1;
        if (b) begin
          n.bdir = -dv;
          t      = m.idx - dv;
        end
      end
      n.idx  = (t + 8) % 8;
      n.tick = 1;
    end
    return n;
  endfunction

  // Model state advances on the same edges as the DUT, resets asynchronously.
  always @(posedge clk or negedge rst) begin
    if (!rst) mdl <= mdl_reset();
    else      mdl <= mdl_next(mdl, bus.clr, bus.run, bus.step, bus.dir, bus.bounce);
  end

  task automatic check(input string nm, input int got, input int exp);
    chk_cnt++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", nm, got, exp, $time);
  endtask

  task automatic check_seq(input string nm, input int got[$], input int exp[$]);
    check({nm, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      check(nm, (i < got.size()) ? got[i] : -1, exp[i]);
  endtask

  // Compare process: DUT vs model every falling edge, and log tick/wrap positions.
  always @(negedge clk) begin
    if (chk_en) begin
      check("idx", int'(bus.idx), mdl.idx);
      check("idx_en", int'(bus.idx_en), mdl.en);
      check("tick", int'(bus.tick), mdl.tick);
      check("wrap", int'(bus.wrap), mdl.wrap);
      if (bus.tick) tick_q.push_back(int'(bus.idx));
      if (bus.wrap) wrap_q.push_back(int'(bus.idx));
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    tick_q.delete();
    wrap_q.delete();
  endtask

  int exp_q[$];

  initial begin
    rst = 1'b0;
    bus.clr = 1'b0; bus.run = 1'b0; bus.step = 1'b0; bus.dir = 1'b0; bus.bounce = 1'b0;
    cycles(3);
    rst = 1'b1;
    chk_en = 1'b1;

    // Reset / idle hold
    cycles(20);
    check("idle_idx", int'(bus.idx), 0);
    check("idle_en", int'(bus.idx_en), 0);
    check("idle_ticks", tick_q.size(), 0);

    // Up scan with wrap
    bus.run = 1'b1;
    cycles(1);
    check("up_en", int'(bus.idx_en), 1);
    check("up_start", int'(bus.idx), 0);
    cycles(32);
    exp_q = '{1, 2, 3, 4, 5, 6, 7, 0};
    check_seq("up_seq", tick_q, exp_q);
    exp_q = '{0};
    check_seq("up_wrap", wrap_q, exp_q);
    bus.clr = 1'b1; bus.run = 1'b0;
    cycles(1);
    bus.clr = 1'b0;
    clear_logs();
    cycles(2);

    // Down scan
    bus.dir = 1'b1; bus.run = 1'b1;
    cycles(1);
    check("down_start", int'(bus.idx), 7);
    cycles(32);
    exp_q = '{6, 5, 4, 3, 2, 1, 0, 7};
    check_seq("down_seq", tick_q, exp_q);
    exp_q = '{7};
    check_seq("down_wrap", wrap_q, exp_q);
    bus.clr = 1'b1; bus.run = 1'b0;
    cycles(1);
    bus.clr = 1'b0;
    clear_logs();
    cycles(2);

    // Bounce
    bus.dir = 1'b0; bus.bounce = 1'b1; bus.run = 1'b1;
    cycles(1);
    check("bnc_start", int'(bus.idx), 0);
    cycles(60);
    exp_q = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
    check_seq("bnc_seq", tick_q, exp_q);
    exp_q = '{6, 1};
    check_seq("bnc_wrap", wrap_q, exp_q);
    bus.clr = 1'b1; bus.run = 1'b0; bus.bounce = 1'b0;
    cycles(1);
    bus.clr = 1'b0;
    clear_logs();
    cycles(2);

    // Pause and step
    bus.run = 1'b1;
    cycles(13);
    check("pre_pause_idx", int'(bus.idx), 3);
    clear_logs();
    bus.run = 1'b0;
    cycles(50);
    check("pause_idx", int'(bus.idx), 3);
    check("pause_en", int'(bus.idx_en), 1);
    check("pause_ticks", tick_q.size(), 0);
    for (int i = 0; i < 3; i++) begin
      bus.step = 1'b1;
      cycles(5);
      bus.step = 1'b0;
      cycles(5);
    end
    exp_q = '{4, 5, 6};
    check_seq("step_seq", tick_q, exp_q);
    clear_logs();
    bus.step = 1'b1;
    cycles(20);
    bus.step = 1'b0;
    cycles(3);
    exp_q = '{7};
    check_seq("step_held", tick_q, exp_q);
    clear_logs();
    bus.dir = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.step = 1'b1;
      cycles(5);
      bus.step = 1'b0;
      cycles(5);
    end
    exp_q = '{6, 5};
    check_seq("step_down", tick_q, exp_q);
    bus.dir = 1'b0;

    // Clear from pause, then clear overriding run
    bus.clr = 1'b1;
    cycles(1);
    check("clr_idx", int'(bus.idx), 0);
    check("clr_en", int'(bus.idx_en), 0);
    bus.run = 1'b1;
    cycles(5);
    check("clr_run_idx", int'(bus.idx), 0);
    check("clr_run_en", int'(bus.idx_en), 0);
    bus.clr = 1'b0; bus.run = 1'b0;
    cycles(2);

    // Asynchronous reset mid-scan
    bus.run = 1'b1;
    cycles(25);
    check("pre_rst_idx", int'(bus.idx), 6);
    check("pre_rst_tick", int'(bus.tick), 1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_idx", int'(bus.idx), 0);
    check("arst_en", int'(bus.idx_en), 0);
    check("arst_tick", int'(bus.tick), 0);
    check("arst_wrap", int'(bus.wrap), 0);
    cycles(2);
    rst = 1'b1;
    cycles(1);
    check("restart_en", int'(bus.idx_en), 1);
    check("restart_idx", int'(bus.idx), 0);
    cycles(4);
    check("restart_adv", int'(bus.idx), 1);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
